led_share_arbiter: RTL and testbench

LED_SHARE_ARBITER -- requirements
Module: led_share_arbiter

---
 rtl/led_arb_pkg.sv | 18 +
 rtl/led_arb_rr_pick.sv | 27 ++
 rtl/led_share_arbiter.sv | 134 +++++++++++++
 tb/tb_led_share_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// rtl/led_arb_pkg.sv - shared types and constants for the LED share arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    BLANK = 2'd2
  } arb_state_e;

  localparam int LED_W           = 8;
  localparam int NUM_SRC_DEFAULT = 4;

  // Index width for n sources; a single source still needs a 1-bit OWNER.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_arb_rr_pick.sv
// rtl/led_arb_rr_pick.sv - combinational round-robin picker: first requester at or after rr_ptr, with wrap.
module led_arb_rr_pick
  import led_arb_pkg::*;
#(
  parameter  int NUM_SRC = NUM_SRC_DEFAULT,
  localparam int OW      = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] REQ,
  input  logic [OW-1:0]      rr_ptr,
  output logic               valid,
  output logic [OW-1:0]      index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!valid && REQ[i] && (((int'(rr_ptr) + k) % NUM_SRC) == i)) begin
          valid = 1'b1;
          index = OW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/led_share_arbiter.sv
// rtl/led_share_arbiter.sv - time-sliced LED ownership arbiter with dark gap between owners.
// Optional grant counter output enabled by LED_ARB_GRANT_CNT_EN.
module led_share_arbiter
  import led_arb_pkg::*;
#(
  parameter  int NUM_SRC      = NUM_SRC_DEFAULT,
  parameter  int DWELL_CYCLES = 50000000,
  parameter  int BLANK_CYCLES = 2,
  localparam int OW           = idx_w(NUM_SRC)
) (
  input  logic                     EXTCLK,
  input  logic                     RST,
  input  logic [NUM_SRC-1:0]       REQ,
  input  logic [NUM_SRC*LED_W-1:0] SRC_DATA,
  input  logic                     HOLD,
  output logic [NUM_SRC-1:0]       GNT,
  output logic [OW-1:0]            OWNER,
  output logic [LED_W-1:0]         LEDG,
`ifdef LED_ARB_GRANT_CNT_EN
  output logic                     SWITCH_PULSE,
  output logic [15:0]              GRANT_CNT
`else
  output logic                     SWITCH_PULSE
`endif
);

  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  arb_state_e           state, state_d;
  logic [OW-1:0]        rr_ptr, rr_ptr_d, owner_d;
  logic [DW-1:0]        dwell, dwell_d;
  logic [BW-1:0]        blank, blank_d;
  logic [NUM_SRC-1:0]   gnt_d, owner_mask;
  logic [LED_W-1:0]     ledg_d, owner_data;
  logic                 pulse_d;
  logic                 pick_valid;
  logic [OW-1:0]        pick_index;
  logic                 owner_req, others_req, expire, leave_own;

  led_arb_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .REQ    (REQ),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_index)
  );

  assign owner_mask = NUM_SRC'(1) << OWNER;
  assign owner_req  = |(REQ & owner_mask);
  assign others_req = |(REQ & ~owner_mask);
  assign expire     = (dwell == DWELL_LAST);
  // A released owner leaves unconditionally; expiry only preempts when someone else waits.
  assign leave_own  = !owner_req || (!HOLD && expire && others_req);

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (OWNER == OW'(i)) owner_data = SRC_DATA[i*LED_W +: LED_W];
    end
  end

  always_ff @(posedge EXTCLK) begin
    if (RST) begin
      state        <= IDLE;
      GNT          <= '0;
      LEDG         <= '0;
      OWNER        <= '0;
      SWITCH_PULSE <= 1'b0;
      rr_ptr       <= '0;
      dwell        <= '0;
      blank        <= '0;
    end else begin
      state        <= state_d;
      GNT          <= gnt_d;
      LEDG         <= ledg_d;
      OWNER        <= owner_d;
      SWITCH_PULSE <= pulse_d;
      rr_ptr       <= rr_ptr_d;
      dwell        <= dwell_d;
      blank        <= blank_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pick_valid) state_d = OWN;
      OWN:     if (leave_own) state_d = BLANK;
      BLANK:   if (blank == BLANK_LAST) state_d = pick_valid ? OWN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = '0;
    ledg_d   = '0;
    owner_d  = OWNER;
    pulse_d  = 1'b0;
    rr_ptr_d = rr_ptr;
    dwell_d  = dwell;
    blank_d  = blank;
    case (state)
      OWN: begin
        if (leave_own) begin
          rr_ptr_d = (OWNER == OW'(NUM_SRC - 1)) ? '0 : OWNER + 1'b1;
          blank_d  = '0;
        end else begin
          gnt_d  = GNT;
          ledg_d = owner_data;
          if (!HOLD) dwell_d = expire ? '0 : dwell + 1'b1;
        end
      end
      BLANK:   if (blank != BLANK_LAST) blank_d = blank + 1'b1;
      default: ;
    endcase
    if (state != OWN && state_d == OWN) begin
      gnt_d   = NUM_SRC'(1) << pick_index;
      owner_d = pick_index;
      pulse_d = 1'b1;
      dwell_d = '0;
    end
  end

`ifdef LED_ARB_GRANT_CNT_EN
  always_ff @(posedge EXTCLK) begin
    if (RST) GRANT_CNT <= '0;
    else if (SWITCH_PULSE && GRANT_CNT != 16'hFFFF) GRANT_CNT <= GRANT_CNT + 16'd1;
  end
`else
`endif

endmodule

// File: tb/tb_led_share_arbiter.sv
// tb/tb_led_share_arbiter.sv - scoreboard bench for led_share_arbiter (DWELL=8, BLANK=2).
module tb_led_share_arbiter;

  localparam int NS  = 4;
  localparam int DWC = 8;
  localparam int BLC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic        hold;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  ledg;
  logic        pulse;
`ifdef LED_ARB_GRANT_CNT_EN
  logic [15:0] gcnt;
`endif

  always #5 clk = ~clk;

  led_share_arbiter #(.NUM_SRC(NS), .DWELL_CYCLES(DWC), .BLANK_CYCLES(BLC)) dut (
    .EXTCLK       (clk),
    .RST          (rst),
    .REQ          (req),
    .SRC_DATA     (data),
    .HOLD         (hold),
    .GNT          (gnt),
    .OWNER        (owner),
    .LEDG         (ledg),
    .SWITCH_PULSE (pulse)
`ifdef LED_ARB_GRANT_CNT_EN
    , .GRANT_CNT  (gcnt)
`endif
  );

  typedef struct packed {
    logic [3:0]  gnt;
    logic [7:0]  led;
    logic [1:0]  owner;
    logic        pulse;
    logic [15:0] gcnt;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: 0 idle, 1 own, 2 blank
  int         m_state, m_owner, m_ptr, m_dwell, m_blank, m_gcnt;
  logic [3:0] m_gnt;
  logic [7:0] m_led;
  logic       m_pulse;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < NS; k++) begin
      int i;
      i = (ptr + k) % NS;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_grant(input int p);
    m_state = 1;
    m_owner = p;
    m_gnt   = 4'b0001 << p;
    m_pulse = 1'b1;
    m_dwell = 0;
  endtask

  task automatic model_step();
    int p;
    logic [3:0] mask;
    exp_t e;
    if (rst) begin
      m_state = 0; m_owner = 0; m_ptr = 0; m_dwell = 0; m_blank = 0; m_gcnt = 0;
      m_gnt = 0; m_led = 0; m_pulse = 0;
    end else begin
      if (m_pulse && m_gcnt < 65535) m_gcnt++;
      m_pulse = 1'b0;
      case (m_state)
        0: begin
          m_gnt = 0; m_led = 0;
          p = pick(req, m_ptr);
          if (p >= 0) m_grant(p);
        end
        1: begin
          mask = 4'b0001 << m_owner;
          if (!req[m_owner] || (!hold && m_dwell == DWC - 1 && (req & ~mask) != 4'b0000)) begin
            m_state = 2; m_gnt = 0; m_led = 0; m_ptr = (m_owner + 1) % NS; m_blank = 0;
          end else begin
            m_led = data[m_owner*8 +: 8];
            if (!hold) m_dwell = (m_dwell == DWC - 1) ? 0 : m_dwell + 1;
          end
        end
        default: begin
          m_gnt = 0; m_led = 0;
          if (m_blank == BLC - 1) begin
            p = pick(req, m_ptr);
            if (p >= 0) m_grant(p);
            else m_state = 0;
          end else m_blank++;
        end
      endcase
    end
    e.gnt = m_gnt; e.led = m_led; e.owner = m_owner[1:0]; e.pulse = m_pulse; e.gcnt = m_gcnt[15:0];
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val("gnt", gnt, e.gnt);
      check_val("ledg", ledg, e.led);
      check_val("owner", owner, e.owner);
      check_val("pulse", pulse, e.pulse);
`ifdef LED_ARB_GRANT_CNT_EN
      check_val("gcnt", gcnt, e.gcnt);
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; hold = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic logic [3:0] contention_gnt(input int i);
    if (i < 8)  return 4'b0001;
    if (i < 10) return 4'b0000;
    if (i < 18) return 4'b0010;
    if (i < 20) return 4'b0000;
    return 4'b0001;
  endfunction

  initial begin
    int npulse;
    int nbad;
    rst = 1'b1; req = 4'b1111; hold = 1'b0; data = 32'h4433_2211;

    // Reset held with all sources requesting
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_gnt", gnt, 32'h0);
      check_val("rst_ledg", ledg, 32'h0);
      check_val("rst_owner", owner, 32'h0);
    end

    // Contention between sources 0 and 1
    rst = 1'b0; req = 4'b0011; npulse = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      check_val($sformatf("cont_gnt_%0d", i), gnt, contention_gnt(i));
      if (pulse) npulse++;
    end
    check_val("cont_pulses", npulse, 3);

    // Early release of owner 2 at dwell count 3
    do_reset();
    req = 4'b0100; data = 32'h11A5_2233;
    tick();
    for (int i = 0; i < 3; i++) tick();
    check_val("early_ledg", ledg, 32'hA5);
    req = 4'b0000;
    tick();
    check_val("early_blank_gnt", gnt, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check_val("early_idle_gnt", gnt, 32'h0);
    check_val("early_idle_ledg", ledg, 32'h0);
    check_val("early_idle_owner", owner, 32'h2);

    // HOLD blocks preemption
    do_reset();
    req = 4'b1001; hold = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    check_val("hold_gnt", gnt, 32'h1);
    hold = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_val("hold_dwell_gnt", gnt, 32'h1);
    for (int i = 0; i < 3; i++) tick();
    check_val("hold_next_gnt", gnt, 32'h8);
    check_val("hold_next_pulse", pulse, 32'h1);

    // Wrap from owner 3, then a solo requester
    do_reset();
    req = 4'b1000;
    tick();
    check_val("wrap_own3", gnt, 32'h8);
    req = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    check_val("wrap_gnt", gnt, 32'h1);
    req = 4'b0100;
    for (int i = 0; i < 3; i++) tick();
    check_val("solo_first_gnt", gnt, 32'h4);
    npulse = 0; nbad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pulse) npulse++;
      if (gnt !== 4'b0100) nbad++;
    end
    check_val("solo_pulses", npulse, 0);
    check_val("solo_gnt_breaks", nbad, 0);

    // Reset pulsed in a BLANK cycle whose rr_ptr would favour source 1
    do_reset();
    req = 4'b0011;
    tick();
    req = 4'b0010;
    tick();
    check_val("midrst_in_blank", gnt, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midrst_gnt", gnt, 32'h0);
`ifdef LED_ARB_GRANT_CNT_EN
    check_val("midrst_gcnt", gcnt, 32'h0);
`endif
    req = 4'b0011;
    tick();
    check_val("midrst_next_gnt", gnt, 32'h1);

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 7) == 0);
      data = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
